// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Holds the PC, reads a synchronous
//            instruction memory, and presents a registered instruction to
//            decode, with a 1-entry skid buffer that absorbs stalls.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int                  PC_WIDTH    = 12,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_en,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   load_pc,
    input  logic [PC_WIDTH-1:0]    load_pc_val,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    instr_pc
);

    localparam logic [PC_WIDTH-1:0]    c_pc_one = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [INSTR_WIDTH-1:0] c_nop    = '0;

    logic [PC_WIDTH-1:0]    pc_q,          pc_d;
    logic                   req_valid_q,   req_valid_d;
    logic [PC_WIDTH-1:0]    req_pc_q,      req_pc_d;
    logic [INSTR_WIDTH-1:0] instr_q,       instr_d;
    logic [PC_WIDTH-1:0]    instr_pc_q,    instr_pc_d;
    logic                   instr_valid_q, instr_valid_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q,  skid_instr_d;
    logic [PC_WIDTH-1:0]    skid_pc_q,     skid_pc_d;
    logic                   skid_valid_q,  skid_valid_d;

    logic w_accept;
    logic w_jump;
    logic w_out_free;
    logic w_issue;

    assign w_accept   = instr_valid_q & ~stall;
    assign w_jump     = w_accept & load_pc;
    assign w_out_free = ~instr_valid_q | ~stall;
    // A held output with a read already returning leaves only the skid free,
    // so no further read may be launched until something drains.
    assign w_issue    = ~rst & ~w_jump & ~skid_valid_q
                      & ~(stall & instr_valid_q & req_valid_q);

    always_comb begin
        pc_d          = pc_q;
        req_valid_d   = req_valid_q;
        req_pc_d      = req_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        skid_valid_d  = skid_valid_q;

        if (w_jump) begin
            pc_d          = load_pc_val;
            req_valid_d   = 1'b0;
            skid_valid_d  = 1'b0;
            instr_valid_d = 1'b0;
            instr_d       = c_nop;
        end else begin
            if (w_issue) begin
                req_pc_d    = pc_q;
                pc_d        = pc_q + c_pc_one;
                req_valid_d = 1'b1;
            end else begin
                req_valid_d = 1'b0;
            end

            if (req_valid_q) begin
                if (w_out_free) begin
                    if (skid_valid_q) begin
                        instr_d       = skid_instr_q;
                        instr_pc_d    = skid_pc_q;
                        instr_valid_d = 1'b1;
                        skid_instr_d  = imem_rdata;
                        skid_pc_d     = req_pc_q;
                        skid_valid_d  = 1'b1;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = req_pc_q;
                        instr_valid_d = 1'b1;
                    end
                end else begin
                    skid_instr_d = imem_rdata;
                    skid_pc_d    = req_pc_q;
                    skid_valid_d = 1'b1;
                end
            end else if (w_out_free) begin
                if (skid_valid_q) begin
                    instr_d       = skid_instr_q;
                    instr_pc_d    = skid_pc_q;
                    instr_valid_d = 1'b1;
                    skid_valid_d  = 1'b0;
                end else begin
                    instr_valid_d = 1'b0;
                    instr_d       = c_nop;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            req_valid_q   <= 1'b0;
            req_pc_q      <= '0;
            instr_q       <= c_nop;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            skid_instr_q  <= c_nop;
            skid_pc_q     <= '0;
            skid_valid_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_valid_q   <= req_valid_d;
            req_pc_q      <= req_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            skid_valid_q  <= skid_valid_d;
        end
    end

    assign imem_en     = w_issue;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign instr_pc    = instr_pc_q;

endmodule
`default_nettype wire
